// File: rtl/wait_state_mem.sv
// Word-organised RAM responder for the core data-memory bus with a fixed number of
// wait states between request capture and the one-cycle ready_o completion pulse.
module wait_state_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        write_enable_i,
  input  logic [3:0]  byte_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic [AddrW-1:0] idx_q;
  logic [31:0]      wd_q;
  logic [31:0]      rd_q;
  logic             ready_q;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [AddrW-1:0] idx_in;
  logic             acc_en;
  logic             acc_we;
  logic [3:0]       acc_be;
  logic [AddrW-1:0] acc_idx;
  logic [31:0]      acc_wd;
  logic             unused_addr;

  assign idx_in      = addr_i[AddrW+1:2];
  assign unused_addr = ^{addr_i[31:AddrW+2], addr_i[1:0]};

  // The access happens on the edge that enters StResp. Without wait states that is the
  // capture edge itself, so the live bus fields are used instead of the captured copy.
  always_comb begin
    acc_en  = 1'b0;
    acc_we  = we_q;
    acc_be  = be_q;
    acc_idx = idx_q;
    acc_wd  = wd_q;
    unique case (state_q)
      StIdle: begin
        if (WAIT_CYCLES == 0) begin
          acc_en  = mem_req_i;
          acc_we  = write_enable_i;
          acc_be  = byte_enable_i;
          acc_idx = idx_in;
          acc_wd  = write_data_i;
        end
      end
      StWait:  acc_en = (cnt_q == 4'd0);
      default: acc_en = 1'b0;
    endcase
    // A clock edge seen while reset is held must never commit an abandoned write.
    if (!rst_i) begin
      acc_en = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      idx_q   <= '0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_req_i) begin
            we_q  <= write_enable_i;
            be_q  <= byte_enable_i;
            idx_q <= idx_in;
            wd_q  <= write_data_i;
            if (WAIT_CYCLES == 0) begin
              state_q <= StResp;
              ready_q <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
        end
      endcase
      if (acc_en && !acc_we) begin
        rd_q <= mem_q[acc_idx];
      end
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk_i) begin
    if (acc_en && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wd[8*i +: 8];
        end
      end
    end
  end

  assign read_data_o = rd_q;
  assign ready_o     = ready_q;

endmodule

// File: tb/tb_wait_state_mem.sv
// Directed bench: a two-wait-state instance driven from a vector table plus corner
// sequences, and a zero-wait-state instance for back-to-back streaming.
module tb_wait_state_mem;

  logic        clk;
  logic        rst;
  logic        req2, we2, req0, we0;
  logic [3:0]  be2, be0;
  logic [31:0] addr2, wd2, addr0, wd0;
  logic [31:0] rd2, rd0;
  logic        rdy2, rdy0;

  int checks;
  int failures;

  wait_state_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_req_i     (req2),
    .write_enable_i(we2),
    .byte_enable_i (be2),
    .addr_i        (addr2),
    .write_data_i  (wd2),
    .read_data_o   (rd2),
    .ready_o       (rdy2)
  );

  wait_state_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_req_i     (req0),
    .write_enable_i(we0),
    .byte_enable_i (be0),
    .addr_i        (addr0),
    .write_data_i  (wd0),
    .read_data_o   (rd0),
    .ready_o       (rdy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[13];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One complete transaction; lat counts rising edges from request presentation until
  // ready_o is observed (-1 on timeout), pulse_ok says ready_o dropped after one cycle.
  task automatic txn(input bit sel0, input logic we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat, output bit pulse_ok);
    bit got;
    @(negedge clk);
    if (sel0) begin
      req0 = 1'b1; we0 = we; be0 = be; addr0 = addr; wd0 = wd;
    end else begin
      req2 = 1'b1; we2 = we; be2 = be; addr2 = addr; wd2 = wd;
    end
    got = 1'b0;
    lat = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (sel0 ? rdy0 : rdy2) got = 1'b1;
    end
    if (!got) lat = -1;
    rd = sel0 ? rd0 : rd2;
    req0 = 1'b0;
    req2 = 1'b0;
    @(posedge clk);
    #1;
    pulse_ok = !(sel0 ? rdy0 : rdy2);
  endtask

  logic [31:0] rd;
  int          lat;
  bit          pok;
  bit          got;
  int          idx;
  int          last_c;
  logic [31:0] stream_exp[3];

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    req2 = 1'b0; we2 = 1'b0; be2 = 4'h0; addr2 = 32'd0; wd2 = 32'd0;
    req0 = 1'b0; we0 = 1'b0; be0 = 4'h0; addr0 = 32'd0; wd0 = 32'd0;

    vecs[0]  = '{1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{1'b0, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 4'h4, 32'h10,   32'h00AA0000, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 4'hF, 32'h10,   32'h0,        32'hDEAABEEF};
    vecs[4]  = '{1'b1, 4'hF, 32'h20,   32'h11111111, 32'hDEAABEEF};
    vecs[5]  = '{1'b0, 4'hF, 32'h20,   32'h0,        32'h11111111};
    vecs[6]  = '{1'b1, 4'hF, 32'h1004, 32'h00000055, 32'h11111111};
    vecs[7]  = '{1'b0, 4'hF, 32'h4,    32'h0,        32'h00000055};
    vecs[8]  = '{1'b0, 4'hF, 32'h7,    32'h0,        32'h00000055};
    vecs[9]  = '{1'b1, 4'hF, 32'h30,   32'h12345678, 32'h00000055};
    vecs[10] = '{1'b1, 4'h0, 32'h30,   32'hFFFFFFFF, 32'h00000055};
    vecs[11] = '{1'b0, 4'hF, 32'h30,   32'h0,        32'h12345678};
    vecs[12] = '{1'b0, 4'h0, 32'h10,   32'h0,        32'hDEAABEEF};

    repeat (3) @(posedge clk);
    #1;
    check32("reset_ready2", {31'd0, rdy2}, 32'd0);
    check32("reset_rd2", rd2, 32'd0);
    check32("reset_ready0", {31'd0, rdy0}, 32'd0);
    check32("reset_rd0", rd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      txn(1'b0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, rd, lat, pok);
      check32($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      check32($sformatf("vec%0d_pulse", i), {31'd0, pok}, 32'd1);
      check32($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end

    // Request fields changed during the wait must not affect the captured read.
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b0; be2 = 4'hF; addr2 = 32'h20; wd2 = 32'h0;
    @(posedge clk);
    @(negedge clk);
    we2 = 1'b1; addr2 = 32'h10; wd2 = 32'h0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #1;
      if (rdy2) got = 1'b1;
    end
    check32("midwait_ready_seen", {31'd0, got}, 32'd1);
    check32("midwait_rd", rd2, 32'h11111111);
    req2 = 1'b0;
    we2 = 1'b0;
    @(posedge clk);
    txn(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, rd, lat, pok);
    check32("midwait_ram_intact", rd, 32'hDEAABEEF);

    // Reset during the wait of a write abandons it.
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; be2 = 4'hF; addr2 = 32'h20; wd2 = 32'h22222222;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check32("midreset_ready", {31'd0, rdy2}, 32'd0);
    check32("midreset_rd", rd2, 32'd0);
    repeat (2) @(posedge clk);
    req2 = 1'b0;
    we2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    txn(1'b0, 1'b0, 4'hF, 32'h20, 32'h0, rd, lat, pok);
    check32("midreset_ram_intact", rd, 32'h11111111);
    check32("midreset_latency", 32'(lat), 32'd3);

    // Zero-wait instance: preload, then stream reads with req held high.
    stream_exp[0] = 32'hA0A0A0A0;
    stream_exp[1] = 32'hB1B1B1B1;
    stream_exp[2] = 32'hC2C2C2C2;
    for (int i = 0; i < 3; i++) begin
      txn(1'b1, 1'b1, 4'hF, 32'(i * 4), stream_exp[i], rd, lat, pok);
      check32($sformatf("w0_write%0d_latency", i), 32'(lat), 32'd1);
      check32($sformatf("w0_write%0d_pulse", i), {31'd0, pok}, 32'd1);
    end
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; be0 = 4'hF; addr0 = 32'h0;
    idx = 0;
    last_c = 0;
    for (int c = 1; c <= 20 && idx < 3; c++) begin
      @(posedge clk);
      #1;
      if (rdy0) begin
        check32($sformatf("stream%0d_rd", idx), rd0, stream_exp[idx]);
        if (idx == 0) check32("stream_first_edge", 32'(c), 32'd1);
        else check32($sformatf("stream%0d_interval", idx), 32'(c - last_c), 32'd2);
        last_c = c;
        idx++;
        addr0 = 32'(idx * 4);
      end
    end
    req0 = 1'b0;
    check32("stream_count", 32'(idx), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
